// File: rtl/inst_fetch.sv
// Instruction fetch: samples the PC, reads the instruction ROM synchronously and queues
// {pc, instruction} for decode in a small FIFO; pc_hold back-pressures the PC source.
module inst_fetch #(
  parameter int unsigned        ADDR_W    = 8,
  parameter int unsigned        INST_W    = 32,
  parameter int unsigned        ROM_DEPTH = 256,
  parameter int unsigned        BUF_DEPTH = 3,
  parameter logic [INST_W-1:0]  NOP_INST  = 32'h00000013,
  parameter                     INIT_FILE = ""
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [ADDR_W-1:0] pc_in,
  output logic              pc_hold,
  input  logic              flush,
  output logic              inst_valid,
  input  logic              inst_ready,
  output logic [INST_W-1:0] inst_out,
  output logic [ADDR_W-1:0] pc_out
);

  localparam int unsigned RA_W  = (ROM_DEPTH > 1) ? $clog2(ROM_DEPTH) : 1;
  localparam int unsigned PTR_W = (BUF_DEPTH > 1) ? $clog2(BUF_DEPTH) : 1;
  localparam int unsigned CNT_W = $clog2(BUF_DEPTH + 1);
  localparam logic [PTR_W-1:0] PTR_LAST = PTR_W'(BUF_DEPTH - 1);
  localparam logic [CNT_W:0]   DEPTH_C  = (CNT_W + 1)'(BUF_DEPTH);

  logic [INST_W-1:0] rom_mem [ROM_DEPTH];

  logic [INST_W-1:0] rom_q;
  logic [ADDR_W-1:0] pc_q;
  logic              inflight_q, inflight_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [PTR_W-1:0]  rd_q, rd_d, wr_q, wr_d;
  logic [INST_W-1:0] inst_mem [BUF_DEPTH];
  logic [ADDR_W-1:0] pc_mem   [BUF_DEPTH];

  logic issue, push, pop, in_range;

  // Non-power-of-two depths wrap explicitly instead of relying on pointer overflow.
  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    return (p == PTR_LAST) ? '0 : p + PTR_W'(1);
  endfunction

  assign pc_hold    = ({1'b0, cnt_q} + (CNT_W + 1)'(inflight_q)) >= DEPTH_C;
  assign inst_valid = (cnt_q != '0);
  assign inst_out   = inst_valid ? inst_mem[rd_q] : '0;
  assign pc_out     = inst_valid ? pc_mem[rd_q]   : '0;

  assign in_range = (32'(pc_in) < ROM_DEPTH);
  assign issue    = ~rst & ~flush & ~pc_hold;
  assign push     = inflight_q & ~flush;
  assign pop      = inst_valid & inst_ready & ~flush;

  // ROM read stage
  always_ff @(posedge clk) begin
    if (issue) begin
      rom_q <= in_range ? rom_mem[pc_in[RA_W-1:0]] : NOP_INST;
      pc_q  <= pc_in;
    end
  end

  // FIFO write stage
  always_ff @(posedge clk) begin
    if (push && !rst) begin
      inst_mem[wr_q] <= rom_q;
      pc_mem[wr_q]   <= pc_q;
    end
  end

  always_comb begin
    inflight_d = issue;
    cnt_d      = cnt_q;
    rd_d       = rd_q;
    wr_d       = wr_q;
    if (flush) begin
      inflight_d = 1'b0;
      cnt_d      = '0;
      rd_d       = '0;
      wr_d       = '0;
    end else begin
      if (push) wr_d = ptr_inc(wr_q);
      if (pop)  rd_d = ptr_inc(rd_q);
      if (push && !pop)      cnt_d = cnt_q + CNT_W'(1);
      else if (pop && !push) cnt_d = cnt_q - CNT_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      inflight_q <= 1'b0;
      cnt_q      <= '0;
      rd_q       <= '0;
      wr_q       <= '0;
    end else begin
      inflight_q <= inflight_d;
      cnt_q      <= cnt_d;
      rd_q       <= rd_d;
      wr_q       <= wr_d;
    end
  end

endmodule

// File: tb/tb_inst_fetch.sv
// Bench for inst_fetch: scoreboard-driven PC stream on the default instance, plus a
// vector table against a 16-word ROM instance for out-of-range addresses.
module tb_inst_fetch;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst, flush, inst_ready, pc_hold, inst_valid;
  logic [7:0]  pc_in, pc_out;
  logic [31:0] inst_out;

  logic        rst2, flush2, rdy2, pc_hold2, inst_valid2;
  logic [7:0]  pc2, pc_out2;
  logic [31:0] inst_out2;

  inst_fetch dut (
    .clk(clk), .rst(rst), .pc_in(pc_in), .pc_hold(pc_hold), .flush(flush),
    .inst_valid(inst_valid), .inst_ready(inst_ready), .inst_out(inst_out), .pc_out(pc_out)
  );

  inst_fetch #(.ROM_DEPTH(16)) dut2 (
    .clk(clk), .rst(rst2), .pc_in(pc2), .pc_hold(pc_hold2), .flush(flush2),
    .inst_valid(inst_valid2), .inst_ready(rdy2), .inst_out(inst_out2), .pc_out(pc_out2)
  );

  typedef struct packed { logic [7:0] pc; logic [31:0] inst; } ent_t;

  int   n_cmp = 0;
  int   n_bad = 0;
  ent_t q[$];
  ent_t q2[$];
  ent_t inf_e;
  bit   inf_v = 1'b0;
  bit   seq_on = 1'b0;
  int   seq_n = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic logic [31:0] rom_val(input logic [7:0] a);
    return 32'h1000_0000 + {24'h0, a};
  endfunction

  // One clock of the default instance: predict, advance, then compare against the model.
  task automatic step();
    logic        iss, pop;
    logic [7:0]  pc_s;
    logic [31:0] head_s;
    iss    = !rst && !flush && !pc_hold;
    pop    = !rst && !flush && inst_valid && inst_ready;
    pc_s   = pc_in;
    head_s = inst_out;
    if (pop && seq_on) begin
      chk("order", head_s, 32'h1000_0000 + 32'(seq_n));
      seq_n++;
    end
    @(posedge clk);
    #1;
    if (rst || flush) begin
      q.delete();
      inf_v = 1'b0;
    end else begin
      if (pop && q.size() > 0) q.delete(0);
      if (inf_v) q.push_back(inf_e);
      inf_v = iss;
      inf_e = '{pc: pc_s, inst: rom_val(pc_s)};
    end
    if (iss) pc_in = pc_in + 8'd1;
    chk("valid", {31'b0, inst_valid}, {31'b0, q.size() != 0});
    chk("hold", {31'b0, pc_hold}, {31'b0, (q.size() + int'(inf_v)) >= 3});
    if (q.size() > 0) begin
      chk("head_inst", inst_out, q[0].inst);
      chk("head_pc", {24'b0, pc_out}, {24'b0, q[0].pc});
    end
  endtask

  ent_t tbl[7];
  int   n_out2;

  initial begin
    for (int i = 0; i < 256; i++) dut.rom_mem[i] = 32'h1000_0000 + 32'(i);
    for (int i = 0; i < 16; i++)  dut2.rom_mem[i] = 32'h1000_0000 + 32'(i);
    tbl[0] = '{pc: 8'h00, inst: 32'h1000_0000};
    tbl[1] = '{pc: 8'h05, inst: 32'h1000_0005};
    tbl[2] = '{pc: 8'h0F, inst: 32'h1000_000F};
    tbl[3] = '{pc: 8'h10, inst: 32'h0000_0013};
    tbl[4] = '{pc: 8'h20, inst: 32'h0000_0013};
    tbl[5] = '{pc: 8'hFF, inst: 32'h0000_0013};
    tbl[6] = '{pc: 8'h03, inst: 32'h1000_0003};

    rst = 1'b1; flush = 1'b0; inst_ready = 1'b1; pc_in = 8'h00;
    rst2 = 1'b1; flush2 = 1'b0; rdy2 = 1'b1; pc2 = 8'h00;
    @(posedge clk);
    #1;

    // Test 1: streaming with decode always ready
    step(); step();
    chk("rst_inst", inst_out, 32'h0);
    chk("rst_pc", {24'b0, pc_out}, 32'h0);
    rst = 1'b0; seq_on = 1'b1; seq_n = 0;
    step();
    chk("t1_lat1", {31'b0, inst_valid}, 32'h0);
    step();
    chk("t1_lat2", {31'b0, inst_valid}, 32'h1);
    repeat (12) step();
    chk("t1_count", 32'(seq_n >= 10), 32'h1);

    // Test 2: decode stalled from the start, then released
    rst = 1'b1; seq_on = 1'b0; step();
    rst = 1'b0; inst_ready = 1'b0; pc_in = 8'h00;
    repeat (6) step();
    chk("t2_hold", {31'b0, pc_hold}, 32'h1);
    chk("t2_pc_frozen", {24'b0, pc_in}, 32'h3);
    inst_ready = 1'b1; seq_on = 1'b1; seq_n = 0;
    repeat (8) step();
    chk("t2_pops", 32'(seq_n), 32'd8);

    // Test 3: toggling ready
    rst = 1'b1; seq_on = 1'b0; step();
    rst = 1'b0; pc_in = 8'h00; seq_on = 1'b1; seq_n = 0;
    for (int c = 0; c < 120 && seq_n < 20; c++) begin
      inst_ready = (c % 2 == 0);
      step();
    end
    chk("t3_count", 32'(seq_n >= 20), 32'h1);
    seq_on = 1'b0;

    // Test 4: flush with two entries queued and one read in flight
    rst = 1'b1; step();
    rst = 1'b0; inst_ready = 1'b0; pc_in = 8'h00;
    repeat (3) step();
    chk("t4_pre_hold", {31'b0, pc_hold}, 32'h1);
    flush = 1'b1; step();
    flush = 1'b0;
    chk("t4_valid", {31'b0, inst_valid}, 32'h0);
    chk("t4_hold", {31'b0, pc_hold}, 32'h0);
    pc_in = 8'h40; inst_ready = 1'b1;
    step(); step();
    chk("t4_inst", inst_out, 32'h1000_0040);
    chk("t4_pc", {24'b0, pc_out}, 32'h40);

    // Test 5: reset while the FIFO is full
    rst = 1'b1; step();
    rst = 1'b0; inst_ready = 1'b0; pc_in = 8'h00;
    repeat (5) step();
    chk("t5_full_valid", {31'b0, inst_valid}, 32'h1);
    chk("t5_full_hold", {31'b0, pc_hold}, 32'h1);
    rst = 1'b1; step();
    rst = 1'b0;
    chk("t5_valid", {31'b0, inst_valid}, 32'h0);
    chk("t5_hold", {31'b0, pc_hold}, 32'h0);
    chk("t5_inst0", inst_out, 32'h0);
    pc_in = 8'h05; inst_ready = 1'b1;
    step(); step();
    chk("t5_inst", inst_out, 32'h1000_0005);
    chk("t5_pc", {24'b0, pc_out}, 32'h5);

    // Test 6: 16-word ROM, out-of-range addresses return the NOP
    rst2 = 1'b0;
    chk("t6_rst_valid", {31'b0, inst_valid2}, 32'h0);
    n_out2 = 0;
    for (int i = 0; i < 9; i++) begin
      int idx;
      idx = (i < 7) ? i : 6;
      pc2 = tbl[idx].pc;
      q2.push_back(tbl[idx]);
      @(posedge clk);
      #1;
      chk("t6_hold", {31'b0, pc_hold2}, 32'h0);
      if (inst_valid2 && q2.size() > 0) begin
        chk("t6_inst", inst_out2, q2[0].inst);
        chk("t6_pc", {24'b0, pc_out2}, {24'b0, q2[0].pc});
        q2.delete(0);
        n_out2++;
      end
    end
    chk("t6_count", 32'(n_out2), 32'd8);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
